ldpc_sparse_mult_by_bt: RTL and testbench
=========================================

# ldpc_sparse_mult_by_bt

Transpose companion to the sparse multiply-by-B stage: consumes one 11-word block of a B-structured vector and produces the single word obtained by multiplying by Bᵀ. The block sits on the decode/parity-check side of the LDPC datapath, opposite the encoder's B expansion. For each block, the output is the XOR of:
- word 0 rotated right by 7;
- word 5 unchanged.

All other positions are structurally zero and are ignored. A two-slot ping-pong result buffer lets input collection continue while the output side stalls.

## Interface
- WIDTH, 96, word width in bits; must be > 7.
- i_clock  input  1  sole clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_input_data  input  WIDTH  block word, sent in order as positions 0..10.
- i_input_valid  input  1  input word valid.
- o_input_ready  output  1  input word accepted when valid & ready.
- o_output_data  output  WIDTH  Bᵀ product word.
- o_output_valid  output  1  result available.
- i_output_ready  input  1  downstream accepts the result.
- o_struct_error  output  1  sticky structural-zero violation; see Configuration.

## Operation
- **Input counter `in_count`** (0..10):
  - Increments on each input handshake.
  - Wraps to 0 after position 10.
- **Accumulator `acc`** (WIDTH), on each input handshake:
  - position 0: acc <= {d[6:0], d[WIDTH-1:7]} (rotate right by 7; overwrites, no reset needed between blocks);
  - position 5: acc <= acc ^ d;
  - other positions: acc unchanged.
- **Finalise** on the position-10 handshake:
  - Write the final acc value into the write slot (ping or pong).
  - Set that slot's full flag and toggle the write pointer.
- **Slot FSM per slot**: EMPTY -> FULL on write; FULL -> EMPTY on output handshake while it is the read slot.
- **Read pointer**: toggles on every output handshake.
- **o_output_valid** = full flag of the read slot.
- **o_output_data** = read slot contents when valid, 0 otherwise.
- **o_input_ready** = 0 only when in_count == 10 and both slots are FULL; 1 otherwise, including positions 0..9 with both slots full.
  - Ready is a function of registered state only: no combinational path from i_output_ready.
- **Ordering**: results are emitted strictly in block-completion order.

## Timing
- **Reset (i_reset_n low, asynchronous)**:
  - in_count = 0, acc = 0;
  - both slots EMPTY, both pointers at ping;
  - o_output_valid = 0, o_output_data = 0, o_input_ready = 0 (gated while reset is asserted), o_struct_error = 0.
- **First clock after release**: o_input_ready = 1.
- **Latency**: o_output_valid rises the cycle after the position-10 handshake.
- **Throughput**: one block per 11 input cycles, with no bubbles while a slot is free.
- **Same-cycle events**:
  - Position-10 write and output drain in the same cycle are both legal.
  - The write targets the write slot and the drain targets the read slot.
  - When both slots are full, the write is blocked by ready regardless of the drain in that cycle.
- **Reset mid-block**: the partial block and any buffered results are discarded; the next accepted word is position 0.
- **Valid hold**: o_output_valid/o_output_data stay stable until the output handshake.

## Configuration
- Macro: `LDPC_SPARSE_MULT_BT_ZERO_CHECK_EN`.
- **Defined**:
  - Any input handshake at a position other than 0 or 5 with nonzero data sets o_struct_error.
  - o_struct_error is sticky until reset.
  - Data results are unaffected.
- **Undefined**: no check logic is compiled; o_struct_error is tied to 0.

## Structure
- Package `ldpc_sparse_mult_pkg` holds:
  - BLOCK_LENGTH = 11, ROTATION = 7, NZ_ROT_POS = 0, NZ_ID_POS = 5;
  - slot state typedef {SLOT_EMPTY, SLOT_FULL}.
- One sub-module, `ldpc_pingpong_result_buffer`:
  - two WIDTH slots with write/read pointers and valid/ready output;
  - exports a both_full status to the parent.
- The parent holds the counter, the accumulator and the optional zero check.

## Test plan
- **Single block**: pos0 = 96'h80, pos5 = 96'h2, all others 0, i_output_ready = 1 -> output 96'h3 exactly once, valid one cycle after the 11th word.
- **Rotate wrap**: pos0 = 96'h1, pos5 = 0 -> output = 96'h1 << 89 (bit 89 set).
- **Backpressure**: i_output_ready = 0 while 3 blocks stream.
  - Two results buffer.
  - o_input_ready drops at the third block's position 10 and stays low.
  - Raising ready drains results in order, then the third result follows.
- **Simultaneous events**: one slot full, position-10 handshake in the same cycle as an output handshake -> no lost or duplicated result; next output is valid the following cycle.
- **Reset mid-block and mid-stall**: assert i_reset_n low asynchronously after 6 words with one result pending.
  - All outputs go to 0 immediately.
  - After release, a fresh block produces the correct result with no stale output.
- **Zero check**, with `LDPC_SPARSE_MULT_BT_ZERO_CHECK_EN` defined: pos3 = 96'h4 -> o_struct_error = 1 the next cycle and stays 1; the data result is unchanged.

Source files
------------

// File: rtl/ldpc_sparse_mult_pkg.sv
// ldpc_sparse_mult_pkg
//   Shared constants and types for the sparse multiply-by-B-transpose stage.
//   BLOCK_LENGTH : words per B-structured block
//   ROTATION     : right-rotation applied to the word at NZ_ROT_POS
//   NZ_ROT_POS   : block position carrying the rotated term
//   NZ_ID_POS    : block position carrying the identity term
//   slot_state_e : occupancy of one ping-pong result slot
package ldpc_sparse_mult_pkg;

    localparam int BLOCK_LENGTH = 11;
    localparam int ROTATION     = 7;
    localparam int NZ_ROT_POS   = 0;
    localparam int NZ_ID_POS    = 5;
    localparam int CNT_W        = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/ldpc_pingpong_result_buffer.sv
// ldpc_pingpong_result_buffer
//   Two-slot result buffer. Writes go to the write slot, reads come from the
//   read slot; both pointers toggle on use, so results leave in write order.
//   clk_i        : clock, rising edge
//   rst_n_i      : asynchronous active-low reset
//   wr_en_i      : write wr_data_i into the write slot (caller guarantees a free slot)
//   wr_data_i    : result word to store
//   rd_data_o    : read slot contents, 0 when not valid
//   rd_valid_o   : read slot is full
//   rd_ready_i   : downstream accepts the read slot
//   both_full_o  : both slots full
module ldpc_pingpong_result_buffer
    import ldpc_sparse_mult_pkg::*;
#(
    parameter int WIDTH = 96
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic             both_full_o
);

    slot_state_e      slot_q [2];
    logic [WIDTH-1:0] data_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic             rd_hs;

    assign rd_valid_o  = (slot_q[rd_ptr_q] == SLOT_FULL);
    assign rd_data_o   = rd_valid_o ? data_q[rd_ptr_q] : '0;
    assign both_full_o = (slot_q[0] == SLOT_FULL) && (slot_q[1] == SLOT_FULL);
    assign rd_hs       = rd_valid_o & rd_ready_i;

    // A same-cycle write and drain never hit the same slot: a write needs a
    // free write slot, a drain needs a full read slot, and with one slot full
    // the pointers differ.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= SLOT_EMPTY;
                data_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (wr_en_i) begin
                data_q[wr_ptr_q] <= wr_data_i;
                slot_q[wr_ptr_q] <= SLOT_FULL;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (rd_hs) begin
                slot_q[rd_ptr_q] <= SLOT_EMPTY;
                rd_ptr_q         <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: rtl/ldpc_sparse_mult_by_bt.sv
// ldpc_sparse_mult_by_bt
//   Multiplies one 11-word B-structured block by B-transpose: the result is
//   (word0 rotated right by 7) XOR word5. Results are queued in a ping-pong
//   buffer so input collection continues while the output stalls.
//   Optional macro LDPC_SPARSE_MULT_BT_ZERO_CHECK_EN: flags (sticky) any
//   nonzero word at a structurally-zero position on o_struct_error.
//   i_clock / i_reset_n            : clock, async active-low reset
//   i_input_data/valid, o_input_ready : block word stream, positions 0..10
//   o_output_data/valid, i_output_ready : result word stream
//   o_struct_error                 : sticky structural-zero violation
module ldpc_sparse_mult_by_bt
    import ldpc_sparse_mult_pkg::*;
#(
    parameter int WIDTH = 96
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_input_data,
    input  logic             i_input_valid,
    output logic             o_input_ready,
    output logic [WIDTH-1:0] o_output_data,
    output logic             o_output_valid,
    input  logic             i_output_ready,
    output logic             o_struct_error
);

    logic [CNT_W-1:0] in_count_q, in_count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             in_hs;
    logic             last_pos;
    logic             both_full;
    logic             wr_en;

    assign last_pos = (in_count_q == CNT_W'(BLOCK_LENGTH - 1));
    // Ready depends on registered state only; held low while in reset.
    assign o_input_ready = i_reset_n & ~(last_pos & both_full);
    assign in_hs         = i_input_valid & o_input_ready;
    assign wr_en         = in_hs & last_pos;

    always_comb begin
        in_count_d = in_count_q;
        acc_d      = acc_q;
        if (in_hs) begin
            in_count_d = last_pos ? '0 : in_count_q + CNT_W'(1);
            if (in_count_q == CNT_W'(NZ_ROT_POS))
                acc_d = {i_input_data[ROTATION-1:0], i_input_data[WIDTH-1:ROTATION]};
            else if (in_count_q == CNT_W'(NZ_ID_POS))
                acc_d = acc_q ^ i_input_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            in_count_q <= '0;
            acc_q      <= '0;
        end else begin
            in_count_q <= in_count_d;
            acc_q      <= acc_d;
        end
    end

`ifdef LDPC_SPARSE_MULT_BT_ZERO_CHECK_EN
    logic struct_err_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            struct_err_q <= 1'b0;
        else if (in_hs && (in_count_q != CNT_W'(NZ_ROT_POS)) &&
                 (in_count_q != CNT_W'(NZ_ID_POS)) && (|i_input_data))
            struct_err_q <= 1'b1;
    end

    assign o_struct_error = struct_err_q;
`else
    assign o_struct_error = 1'b0;
`endif

    // Position 10 carries no term, so acc_q already holds the final result.
    ldpc_pingpong_result_buffer #(.WIDTH(WIDTH)) u_buf (
        .clk_i       (i_clock),
        .rst_n_i     (i_reset_n),
        .wr_en_i     (wr_en),
        .wr_data_i   (acc_q),
        .rd_data_o   (o_output_data),
        .rd_valid_o  (o_output_valid),
        .rd_ready_i  (i_output_ready),
        .both_full_o (both_full)
    );

endmodule

// File: tb/tb_ldpc_sparse_mult_by_bt.sv
module tb_ldpc_sparse_mult_by_bt;

    localparam int W = 96;
`ifdef LDPC_SPARSE_MULT_BT_ZERO_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         struct_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ldpc_sparse_mult_by_bt #(.WIDTH(W)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_input_data   (in_data),
        .i_input_valid  (in_valid),
        .o_input_ready  (in_ready),
        .o_output_data  (out_data),
        .o_output_valid (out_valid),
        .i_output_ready (out_ready),
        .o_struct_error (struct_err)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called away from an edge; returns at posedge+1 after the handshake.
    task automatic send_word(input logic [W-1:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++;
            $error("FAIL send_timeout observed ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Sends positions 0..nwords-1; only positions 0 and 5 carry data.
    task automatic send_block(input logic [W-1:0] w0, input logic [W-1:0] w5, input int nwords);
        for (int p = 0; p < nwords; p++)
            send_word(p == 0 ? w0 : (p == 5 ? w5 : '0));
    endtask

    initial begin
        logic [W-1:0] wrap_exp;
        wrap_exp  = 96'd1 << 89;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_valid", W'(out_valid), '0);
        check("rst_data",  out_data, '0);
        check("rst_ready", W'(in_ready), '0);
        check("rst_err",   W'(struct_err), '0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", W'(in_ready), W'(1));
        check("post_rst_valid", W'(out_valid), '0);

        // Single block: 0x80 ror 7 = 0x1, xor 0x2 = 0x3
        out_ready = 1'b1;
        send_block(96'h80, 96'h2, 11);
        check("single_valid", W'(out_valid), W'(1));
        check("single_data",  out_data, 96'h3);
        @(posedge clk); #1;
        check("single_once_valid", W'(out_valid), '0);
        check("single_once_data",  out_data, '0);

        // Rotate wrap: bit 0 lands on bit 89; valid holds while stalled
        out_ready = 1'b0;
        send_block(96'h1, 96'h0, 11);
        check("wrap_data", out_data, wrap_exp);
        @(posedge clk); #1;
        check("wrap_hold_valid", W'(out_valid), W'(1));
        check("wrap_hold_data",  out_data, wrap_exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("wrap_drained", W'(out_valid), '0);

        // Backpressure: three blocks with output stalled
        out_ready = 1'b0;
        send_block(96'h0, 96'hA1, 11);
        send_block(96'h0, 96'hB2, 11);
        check("bp_first_data", out_data, 96'hA1);
        send_block(96'h0, 96'hC3, 10);
        in_data  = '0;
        in_valid = 1'b1;
        check("bp_ready_low", W'(in_ready), '0);
        @(posedge clk); #1;
        check("bp_ready_stays_low", W'(in_ready), '0);
        check("bp_hold_data", out_data, 96'hA1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_second_data", out_data, 96'hB2);
        check("bp_ready_back", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_third_valid", W'(out_valid), W'(1));
        check("bp_third_data",  out_data, 96'hC3);
        @(posedge clk); #1;
        check("bp_empty", W'(out_valid), '0);

        // Simultaneous position-10 write and drain with one slot full
        out_ready = 1'b0;
        send_block(96'h0, 96'h5, 11);
        send_block(96'h0, 96'hE, 10);
        in_data   = '0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("sim_ready", W'(in_ready), W'(1));
        check("sim_pending", out_data, 96'h5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("sim_next_valid", W'(out_valid), W'(1));
        check("sim_next_data",  out_data, 96'hE);
        @(posedge clk); #1;
        check("sim_empty", W'(out_valid), '0);

        // Reset with one result pending and 6 words of the next block taken
        out_ready = 1'b0;
        send_block(96'h0, 96'h77, 11);
        send_block(96'h80, 96'h0, 6);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", W'(out_valid), '0);
        check("mid_rst_data",  out_data, '0);
        check("mid_rst_ready", W'(in_ready), '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_no_stale", W'(out_valid), '0);
        check("mid_rst_ready_up", W'(in_ready), W'(1));
        out_ready = 1'b1;
        // 0x300 ror 7 = 0x6, xor 0x1 = 0x7
        send_block(96'h300, 96'h1, 11);
        check("fresh_valid", W'(out_valid), W'(1));
        check("fresh_data",  out_data, 96'h7);
        check("fresh_err",   W'(struct_err), '0);
        @(posedge clk); #1;
        check("fresh_drained", W'(out_valid), '0);

        // Structural-zero violation at position 3
        for (int p = 0; p < 11; p++) begin
            send_word(p == 0 ? 96'h80 : (p == 3 ? 96'h4 : (p == 5 ? 96'h2 : 96'h0)));
            if (p == 3) check("zc_err_rise", W'(struct_err), W'(EXP_ERR));
        end
        check("zc_data",     out_data, 96'h3);
        check("zc_err_held", W'(struct_err), W'(EXP_ERR));
        @(posedge clk); #1;
        check("zc_err_sticky", W'(struct_err), W'(EXP_ERR));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
